truth_table_sweep_checker: RTL and testbench
============================================

Name: truth_table_sweep_checker

Overview:
- Hardware self-checking harness for small combinational function implementations (gate-level, dataflow and behavioural variants of one function).
- Sweeps every input vector of an IN_W-bit function, waits a settle window, then compares N_IMPL implementation outputs against a golden truth-table mask.
- Reports pass/fail, the first failing vector, which implementations disagreed, and a failing-vector count.
- Sits beside the implementations in lab/sim top levels and replaces per-project hand-written sweep benches.

Parameters:
- IN_W, 4, input vector width; sweeps 2^IN_W vectors.
- N_IMPL, 3, number of implementations checked in parallel.
- GOLDEN, 16'hC0A0, width 2^IN_W; bit k is the required output for input k (default: minterms 5, 7, 14, 15).
- SETTLE, 5, cycles a vector is held before its check; legal range >= 1.
- STOP_ON_FAIL, 1; 1 = end the sweep at the first failing vector, 0 = complete the sweep and count failures.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  starts a sweep; sampled only in IDLE or DONE.
- dut_out  in  N_IMPL  bit i is the output of implementation i for the current vec_out.
- vec_out  out  IN_W  input vector driven to all implementations.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 means no mismatch was seen.
- fail_vec  out  IN_W  first failing vector.
- fail_mask  out  N_IMPL  mismatch bits at fail_vec; bit i = dut_out[i] != GOLDEN[fail_vec].
- err_count  out  IN_W+1  number of failing vectors; a vector counts once however many implementations fail.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
  - rst asserted, including mid-sweep: state=IDLE immediately; vec_out=0, busy=0, done=0, pass=0, fail_vec=0, fail_mask=0, err_count=0, settle counter=0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge: vec_out<=0, counter<=0, results cleared, next=SETTLE.
- SETTLE:
  - Each edge: if counter==SETTLE-1, next=CHECK; else counter++.
  - Occupies exactly SETTLE cycles.
- CHECK (one cycle), evaluating mis = dut_out XOR {N_IMPL{GOLDEN[vec_out]}}:
  - mis!=0: err_count++. If this is the first failure (err_count==0 before the increment), latch fail_vec=vec_out and fail_mask=mis.
  - mis!=0 and STOP_ON_FAIL=1: next=DONE, pass=0.
  - Otherwise, if vec_out==2^IN_W-1: next=DONE, pass=(err_count_next==0).
  - Otherwise: vec_out++, counter<=0, next=SETTLE.
- Timing:
  - Per-vector cost is SETTLE+1 cycles.
  - A full sweep ends with done rising at edge 2^IN_W*(SETTLE+1) after the start-sampling edge; this is edge 96 for the defaults.
  - A stop on vector v ends with done rising at edge (v+1)*(SETTLE+1).
- DONE:
  - Outputs hold, and vec_out holds its last value.
  - start=1 restarts the sweep exactly as from IDLE and clears done, pass and results at that edge.
- Simultaneous events and width rules:
  - start while busy is ignored.
  - rst overrides start.
  - dut_out is only sampled in CHECK.
  - err_count cannot overflow: its maximum is 2^IN_W, which fits in IN_W+1 bits.
  - vec_out never wraps during a sweep.

Test Plan:
- Default parameters, three correct models: pulse start. Required: busy=1 through edge 95; done=1 and pass=1 at edge 96; err_count=0; fail_vec=0; fail_mask=0.
- STOP_ON_FAIL=1, implementation 1 inverted at vector 7 only. Required: done at edge 48, pass=0, fail_vec=7, fail_mask=3'b010, err_count=1, vec_out=7.
- STOP_ON_FAIL=0, implementation 0 wrong at vector 5, implementations 0 and 2 wrong at vector 14. Required: done at edge 96, pass=0, fail_vec=5, fail_mask=3'b001, err_count=2.
- Start pulses at edges 10 and 40 of a running sweep are ignored (done still at 96). A start in DONE restarts the sweep: done drops at that edge, and the second sweep passes at +96.
- Assert rst asynchronously mid-cycle while vec_out=9. Required: all outputs 0 immediately, without a clock edge. After release, a start gives a clean pass at edge 96.
- IN_W=5, N_IMPL=2, SETTLE=1, GOLDEN=32'h8000_0001 with correct models. Required: done and pass at edge 64, final vec_out=31.

Source files
------------

// File: rtl/truth_table_sweep_checker.sv
// -----------------------------------------------------------------------------
// truth_table_sweep_checker
//
// Purpose:
//   Exhaustive truth-table checker for small combinational functions. It
//   drives every IN_W-bit input vector to N_IMPL implementations of the same
//   function. Each vector is held for SETTLE cycles and then checked for one
//   cycle against a golden truth-table mask. It reports pass/fail, the first
//   failing vector and which implementations disagreed there, plus a count of
//   failing vectors.
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous reset, active-high
//   start        in   1        starts a sweep (sampled only in IDLE or DONE)
//   dut_out      in   N_IMPL   bit i = output of implementation i for vec_out
//   vec_out      out  IN_W     input vector driven to all implementations
//   busy         out  1        high in SETTLE and CHECK
//   done         out  1        high in DONE
//   pass         out  1        valid while done; 1 = no mismatch seen
//   fail_vec     out  IN_W     first failing vector
//   fail_mask    out  N_IMPL   mismatch bits at fail_vec
//   err_count    out  IN_W+1   number of failing vectors
//   o_dbg_state  out  2        current FSM state (IDLE=0 SETTLE=1 CHECK=2 DONE=3)
//
// Handshake: start is a request level. It is accepted at any rising edge
// where the FSM is in IDLE or DONE. busy is the "not ready" indication, so a
// start seen while busy=1 is dropped, not queued. Completion is reported by
// done, which is a level that holds until the next accepted start or reset.
// -----------------------------------------------------------------------------
module truth_table_sweep_checker #(
  parameter int                     IN_W         = 4,
  parameter int                     N_IMPL       = 3,
  parameter logic [(1<<IN_W)-1:0]   GOLDEN       = 16'hC0A0,
  parameter int                     SETTLE       = 5,
  parameter bit                     STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_IMPL-1:0] dut_out,
  output logic [IN_W-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IN_W-1:0]   fail_vec,
  output logic [N_IMPL-1:0] fail_mask,
  output logic [IN_W:0]     err_count,
  output logic [1:0]        o_dbg_state
);

  // Settle counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [IN_W-1:0] VEC_LAST = {IN_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IN_W-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [IN_W-1:0]     r_fail_vec;
  logic [N_IMPL-1:0]   r_fail_mask;
  logic [IN_W:0]       r_err_count;

  logic                w_golden_bit;
  logic [N_IMPL-1:0]   w_mis;
  logic                w_any_mis;
  logic [IN_W:0]       w_err_next;

  // Mismatch per implementation for the vector currently applied. Only
  // consumed in CHECK, so dut_out is effectively sampled there alone.
  assign w_golden_bit = GOLDEN[r_vec];
  assign w_mis        = dut_out ^ {N_IMPL{w_golden_bit}};
  assign w_any_mis    = |w_mis;
  // A vector counts once, however many implementations disagree.
  assign w_err_next   = r_err_count + {{IN_W{1'b0}}, w_any_mis};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Restart from DONE behaves exactly like a start from IDLE.
          if (start) begin
            r_state     <= S_SETTLE;
            r_cnt       <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
            r_err_count <= '0;
          end
        end

        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          r_err_count <= w_err_next;
          // First failure: err_count still zero before this increment.
          if (w_any_mis && (r_err_count == '0)) begin
            r_fail_vec  <= r_vec;
            r_fail_mask <= w_mis;
          end

          if (w_any_mis && STOP_ON_FAIL) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
          end else if (r_vec == VEC_LAST) begin
            // Last vector: vec_out stays put, so it never wraps.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state <= S_SETTLE;
            r_vec   <= r_vec + 1'b1;
            r_cnt   <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out     = r_vec;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_vec    = r_fail_vec;
  assign fail_mask   = r_fail_mask;
  assign err_count   = r_err_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// -----------------------------------------------------------------------------
// Bench for truth_table_sweep_checker.
//
// Three checker instances share clk, rst and start:
//   u_stop  : defaults (STOP_ON_FAIL=1)
//   u_nstop : defaults with STOP_ON_FAIL=0
//   u_w5    : IN_W=5, N_IMPL=2, SETTLE=1, GOLDEN=32'h8000_0001
// Each instance gets its own implementation outputs, computed from its own
// vec_out. The implementations are written independently as gate-level,
// minterm dataflow and case-based behavioural models. Faults are planted by
// XORing a per-vector injection mask into the default-width models.
// The scenario table holds the faults and the expected results for each run.
// Edge numbers count rising edges after the edge that samples start (edge 0).
// -----------------------------------------------------------------------------
module tb_truth_table_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;

  logic [2:0] dout_s, dout_n;
  logic [1:0] dout_5;
  logic [3:0] vec_s, vec_n, fv_s, fv_n;
  logic [4:0] vec_5, fv_5, ec_s, ec_n;
  logic [5:0] ec_5;
  logic [2:0] fm_s, fm_n;
  logic [1:0] fm_5;
  logic       busy_s, busy_n, busy_5;
  logic       done_s, done_n, done_5;
  logic       pass_s, pass_n, pass_5;
  logic [1:0] st_s, st_n, st_5;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  truth_table_sweep_checker u_stop (
    .clk(clk), .rst(rst), .start(start), .dut_out(dout_s),
    .vec_out(vec_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_vec(fv_s), .fail_mask(fm_s), .err_count(ec_s), .o_dbg_state(st_s)
  );

  truth_table_sweep_checker #(.STOP_ON_FAIL(1'b0)) u_nstop (
    .clk(clk), .rst(rst), .start(start), .dut_out(dout_n),
    .vec_out(vec_n), .busy(busy_n), .done(done_n), .pass(pass_n),
    .fail_vec(fv_n), .fail_mask(fm_n), .err_count(ec_n), .o_dbg_state(st_n)
  );

  truth_table_sweep_checker #(
    .IN_W(5), .N_IMPL(2), .SETTLE(1), .GOLDEN(32'h8000_0001), .STOP_ON_FAIL(1'b1)
  ) u_w5 (
    .clk(clk), .rst(rst), .start(start), .dut_out(dout_5),
    .vec_out(vec_5), .busy(busy_5), .done(done_5), .pass(pass_5),
    .fail_vec(fv_5), .fail_mask(fm_5), .err_count(ec_5), .o_dbg_state(st_5)
  );

  // ---------------- implementation models ----------------
  // f = minterms 5, 7, 14, 15
  function automatic logic f_gate(input logic [3:0] x);
    return (~x[3] & x[2] & x[0]) | (x[3] & x[2] & x[1]);
  endfunction

  function automatic logic f_flow(input logic [3:0] x);
    return (x == 4'd5) || (x == 4'd7) || (x == 4'd14) || (x == 4'd15);
  endfunction

  function automatic logic f_beh(input logic [3:0] x);
    logic r;
    case (x)
      4'd5, 4'd7, 4'd14, 4'd15: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  // 5-bit function: minterms 0 and 31
  function automatic logic g_flow(input logic [4:0] x);
    return (~|x) | (&x);
  endfunction

  function automatic logic g_beh(input logic [4:0] x);
    logic r;
    case (x)
      5'd0, 5'd31: r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  logic [2:0] inj [16];

  always_comb begin
    dout_s = {f_beh(vec_s), f_flow(vec_s), f_gate(vec_s)} ^ inj[vec_s];
    dout_n = {f_beh(vec_n), f_flow(vec_n), f_gate(vec_n)} ^ inj[vec_n];
    dout_5 = {g_beh(vec_5), g_flow(vec_5)};
  end

  // ---------------- observation mux ----------------
  int         sel;
  logic [4:0] o_vec, o_fv;
  logic [2:0] o_fm;
  logic [5:0] o_ec;
  logic       o_busy, o_done, o_pass;
  logic [1:0] o_st;

  always_comb begin
    o_vec = '0; o_fv = '0; o_fm = '0; o_ec = '0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0; o_st = '0;
    case (sel)
      0: begin
        o_vec = {1'b0, vec_s}; o_fv = {1'b0, fv_s}; o_fm = fm_s; o_ec = {1'b0, ec_s};
        o_busy = busy_s; o_done = done_s; o_pass = pass_s; o_st = st_s;
      end
      1: begin
        o_vec = {1'b0, vec_n}; o_fv = {1'b0, fv_n}; o_fm = fm_n; o_ec = {1'b0, ec_n};
        o_busy = busy_n; o_done = done_n; o_pass = pass_n; o_st = st_n;
      end
      default: begin
        o_vec = vec_5; o_fv = fv_5; o_fm = {1'b0, fm_5}; o_ec = ec_5;
        o_busy = busy_5; o_done = done_5; o_pass = pass_5; o_st = st_5;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: actual=%0d, no expected value queued", name, act);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  localparam int LIMIT = 200;

  function automatic logic [31:0] all_outputs();
    return {6'd0, o_vec, o_busy, o_done, o_pass, o_fv, o_fm, o_ec, o_st};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_val(32'd0);
    check("reset_outputs", all_outputs());
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start so that edge 0 samples it. Optionally re-pulses start for
  // edges ign_a/ign_b. Reports the edge at which done rose (-1 on timeout),
  // whether busy stayed high until then, and whether edge 0 left the
  // selected DUT busy with done low.
  task automatic sweep(input int ign_a, input int ign_b,
                       output int done_edge, output bit busy_ok, output bit start_ok);
    done_edge = -1;
    busy_ok   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_ok = o_busy && !o_done;
    for (int k = 1; k <= LIMIT; k++) begin
      if (k == ign_a || k == ign_b) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (o_done) begin
        done_edge = k;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    int         v_a;
    logic [2:0] m_a;
    int         v_b;
    logic [2:0] m_b;
    logic [2:0] all_m;
    int         e_edge;
    logic       e_pass;
    int         e_fv;
    logic [2:0] e_fm;
    int         e_ec;
    int         e_vec;
  } scen_t;

  scen_t tbl [9];

  int  d_edge;
  bit  b_ok, s_ok;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 0;
    for (int v = 0; v < 16; v++) inj[v] = 3'b000;

    //            sel v_a m_a     v_b m_b     all     edge pass fv fm      ec  vec
    tbl[0] = '{0, -1, 3'b000, -1, 3'b000, 3'b000, 96, 1'b1, 0,  3'b000, 0,  15};
    tbl[1] = '{0,  7, 3'b010, -1, 3'b000, 3'b000, 48, 1'b0, 7,  3'b010, 1,  7};
    tbl[2] = '{1,  5, 3'b001, 14, 3'b101, 3'b000, 96, 1'b0, 5,  3'b001, 2,  15};
    tbl[3] = '{1,  7, 3'b010, -1, 3'b000, 3'b000, 96, 1'b0, 7,  3'b010, 1,  15};
    tbl[4] = '{0, 14, 3'b101, -1, 3'b000, 3'b000, 90, 1'b0, 14, 3'b101, 1,  14};
    tbl[5] = '{1, -1, 3'b000, -1, 3'b000, 3'b111, 96, 1'b0, 0,  3'b111, 16, 15};
    tbl[6] = '{0,  0, 3'b100, -1, 3'b000, 3'b000, 6,  1'b0, 0,  3'b100, 1,  0};
    tbl[7] = '{0, 15, 3'b001, -1, 3'b000, 3'b000, 96, 1'b0, 15, 3'b001, 1,  15};
    tbl[8] = '{2, -1, 3'b000, -1, 3'b000, 3'b000, 64, 1'b1, 0,  3'b000, 0,  31};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      sel = tbl[i].sel;
      for (int v = 0; v < 16; v++) inj[v] = tbl[i].all_m;
      if (tbl[i].v_a >= 0) inj[tbl[i].v_a] = tbl[i].m_a;
      if (tbl[i].v_b >= 0) inj[tbl[i].v_b] = tbl[i].m_b;
      do_reset();
      sweep(0, 0, d_edge, b_ok, s_ok);
      expect_val(tbl[i].e_edge); check($sformatf("t%0d_done_edge", i), d_edge);
      expect_val(1);             check($sformatf("t%0d_busy_hold", i), {31'd0, b_ok});
      expect_val(tbl[i].e_pass); check($sformatf("t%0d_pass", i), {31'd0, o_pass});
      expect_val(tbl[i].e_fv);   check($sformatf("t%0d_fail_vec", i), {27'd0, o_fv});
      expect_val(tbl[i].e_fm);   check($sformatf("t%0d_fail_mask", i), {29'd0, o_fm});
      expect_val(tbl[i].e_ec);   check($sformatf("t%0d_err_count", i), {26'd0, o_ec});
      expect_val(tbl[i].e_vec);  check($sformatf("t%0d_vec_out", i), {27'd0, o_vec});
    end

    // ---- start pulses while busy are ignored; restart from DONE ----
    sel = 0;
    for (int v = 0; v < 16; v++) inj[v] = 3'b000;
    do_reset();
    sweep(10, 40, d_edge, b_ok, s_ok);
    expect_val(96); check("ign_done_edge", d_edge);
    expect_val(1);  check("ign_busy_hold", {31'd0, b_ok});
    expect_val(1);  check("ign_pass", {31'd0, o_pass});
    expect_val(3);  check("done_state", {30'd0, o_st});

    sweep(0, 0, d_edge, b_ok, s_ok);
    expect_val(1);  check("restart_clears_done", {31'd0, s_ok});
    expect_val(96); check("restart_done_edge", d_edge);
    expect_val(1);  check("restart_pass", {31'd0, o_pass});

    // ---- asynchronous reset mid-sweep at vec_out=9 ----
    sel = 0;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 1; k <= LIMIT; k++) begin
        @(posedge clk); #1;
        if (o_vec == 5'd9) begin
          seen = 1'b1;
          break;
        end
      end
      expect_val(1); check("reach_vec9", {31'd0, seen});
    end
    #2;
    rst = 1'b1;
    #1;
    expect_val(0); check("async_reset_outputs", all_outputs());
    expect_val(0); check("async_reset_nstop_vec", {28'd0, vec_n});
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 0, d_edge, b_ok, s_ok);
    expect_val(96); check("post_reset_done_edge", d_edge);
    expect_val(1);  check("post_reset_pass", {31'd0, o_pass});
    expect_val(0);  check("post_reset_err_count", {26'd0, o_ec});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
